// File: rtl/decoder_control_unit.sv
// Pipeline sequencer for the arithmetic decoder: meters bitstream bytes into the
// decoder window and steps the three pipeline-register enables for one tile.
module decoder_control_unit #(
  parameter int INIT_BYTES    = 2,
  parameter int NUM_SYMBOLS_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_ctrl_n,
  input  logic                     start,
  input  logic [NUM_SYMBOLS_W-1:0] num_symbols,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     load_window,
  input  logic [1:0]               refill_req,
  output logic                     pipeline_reg_1_2,
  output logic                     pipeline_reg_2_3,
  output logic                     pipeline_reg_final,
  output logic                     busy,
  output logic                     done
);

  localparam int INIT_W = $clog2(INIT_BYTES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    REFILL,
    DONE
  } state_t;

  state_t                   state;
  logic [NUM_SYMBOLS_W-1:0] n;
  logic [NUM_SYMBOLS_W-1:0] issued;
  logic [NUM_SYMBOLS_W-1:0] retired;
  logic [INIT_W-1:0]        init_cnt;
  logic [1:0]               pending;
  logic                     v2;
  logic                     v3;

  logic                     transfer;
  logic                     last_retire;
  logic [1:0]               refill_clamped;

  assign byte_ready  = (state == INIT) || (state == REFILL);
  assign transfer    = byte_valid && byte_ready;
  assign load_window = transfer;
  assign busy        = (state == INIT) || (state == RUN) || (state == REFILL);
  assign done        = (state == DONE);

  // Enables are only live in RUN; a pending refill freezes the whole pipe.
  assign pipeline_reg_1_2   = (state == RUN) && (issued < n);
  assign pipeline_reg_2_3   = (state == RUN) && v2;
  assign pipeline_reg_final = (state == RUN) && v3;

  // retired < n whenever a symbol retires, so the increment cannot wrap.
  assign last_retire    = (retired + NUM_SYMBOLS_W'(1)) == n;
  assign refill_clamped = (refill_req == 2'd3) ? 2'd2 : refill_req;

  // NOTE: reset is sampled on the clock edge, and all state uses non-blocking
  // assignments so every register sees pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_ctrl_n) begin
      state    <= IDLE;
      n        <= '0;
      issued   <= '0;
      retired  <= '0;
      init_cnt <= '0;
      pending  <= '0;
      v2       <= 1'b0;
      v3       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n        <= num_symbols;
            issued   <= '0;
            retired  <= '0;
            init_cnt <= '0;
            pending  <= '0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            state    <= (num_symbols == '0) ? DONE : INIT;
          end
        end

        INIT: begin
          if (transfer) begin
            init_cnt <= init_cnt + INIT_W'(1);
            if (init_cnt == INIT_LAST) state <= RUN;
          end
        end

        RUN: begin
          v2 <= pipeline_reg_1_2;
          v3 <= pipeline_reg_2_3;
          if (pipeline_reg_1_2)   issued  <= issued + NUM_SYMBOLS_W'(1);
          if (pipeline_reg_final) retired <= retired + NUM_SYMBOLS_W'(1);
          if (pipeline_reg_final) begin
            if (refill_clamped != 2'd0) begin
              pending <= refill_clamped;
              state   <= REFILL;
            end else if (last_retire) begin
              state <= DONE;
            end
          end
        end

        REFILL: begin
          if (transfer) begin
            pending <= pending - 2'd1;
            if (pending == 2'd1) state <= (retired == n) ? DONE : RUN;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/decoder_control_unit.md
# decoder_control_unit

Pipeline sequencer for the arithmetic decoder, the receive-side counterpart of the encoder's pipeline control unit. It drives the three decoder pipeline-register enables through fill, steady state and drain for one tile of `num_symbols` symbols. It meters bitstream bytes into the decoder window: INIT_BYTES bytes at tile start, then the per-symbol renormalisation refills requested by stage 3. The pipeline stalls while a refill is pending.

## Interface
Parameters:
- INIT_BYTES, 2, bytes loaded into the decoder window before the first symbol issues (≥1)
- NUM_SYMBOLS_W, 16, width of symbol count and internal counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_ctrl_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to decode a tile; honoured only in IDLE
- num_symbols  in  NUM_SYMBOLS_W  symbols in tile, latched when start is honoured
- byte_valid  in  1  bitstream byte available
- byte_ready  out  1  controller accepts a byte; transfer = byte_valid && byte_ready
- load_window  out  1  equals transfer; shifts the byte into the decoder window
- refill_req  in  2  bytes stage 3 needs after renormalisation; sampled only when pipeline_reg_final=1
- pipeline_reg_1_2  out  1  enable: issue next symbol into stage 1→2 register
- pipeline_reg_2_3  out  1  enable: stage 2→3 register
- pipeline_reg_final  out  1  enable: final register, i.e. a symbol retires
- busy  out  1  high in INIT, RUN, REFILL
- done  out  1  one-cycle pulse, tile finished

## Operation
- States: IDLE, INIT, RUN, REFILL, DONE. Registered state, Moore-style outputs plus combinational enables.
- Internal registers: N (latched count), issued, retired, init_cnt, pending (2 b), v2, v3 (stage occupancy).
- IDLE: all enables 0, byte_ready 0. On start: latch N, clear counters and valid bits. N=0 → DONE. Otherwise → INIT.
- INIT: byte_ready=1, enables 0. Each transfer increments init_cnt. The transfer that reaches INIT_BYTES → RUN.
- RUN: byte_ready=0.
  - pipeline_reg_1_2 = (issued<N)
  - pipeline_reg_2_3 = v2
  - pipeline_reg_final = v3
  - On each edge: v2←pipeline_reg_1_2; v3←pipeline_reg_2_3; issued += pipeline_reg_1_2; retired += pipeline_reg_final.
- Warm-up therefore matches the encoder: first RUN cycle enables only 1_2, second enables 1_2 and 2_3, third enables all three. Drain is the mirror image.
- Refill: when pipeline_reg_final=1 and refill_req≠0:
  - pipeline still advances that cycle;
  - pending←min(refill_req,2);
  - next state REFILL.
- REFILL: all enables 0, valid bits and counters hold, byte_ready=1. Each transfer decrements pending. The transfer taking pending 1→0 exits:
  - to DONE if retired==N;
  - otherwise to RUN.
  - A last-symbol refill is completed before DONE.
- RUN with pipeline_reg_final=1, refill_req=0 and retired+1==N → DONE.
- DONE: done=1, enables 0, byte_ready 0; → IDLE next cycle.
- start outside IDLE ignored; byte_valid with byte_ready=0 ignored (no transfer). refill_req=3 treated as 2.
- Counters never wrap: N ≤ 2^NUM_SYMBOLS_W−1, issued and retired saturate at N by construction.

## Timing
- Reset (reset_ctrl_n=0 at edge): state IDLE, counters/v2/v3/pending 0. Every output 0 the cycle after. Reset mid-tile aborts without done.
- start sampled cycle 0 → INIT from cycle 1. With byte_valid held 1, INIT occupies INIT_BYTES cycles.
- INIT_BYTES=2, no refills: RUN begins cycle 3. pipeline_reg_1_2 is high cycles 3..N+2, pipeline_reg_final high cycles 5..N+4, done at cycle N+5, IDLE at N+6.
- Refill of k bytes with byte_valid=1 inserts exactly k stall cycles after the retiring cycle. Each byte_valid=0 cycle in REFILL/INIT adds one cycle.
- Symbol latency stage 1 issue → retire: 2 cycles plus any intervening stall cycles.

## Test plan
- Reset: drive reset_ctrl_n=0 mid-RUN of N=8 → next cycle all outputs 0, state IDLE, no done; a later start decodes normally.
- N=1, byte_valid=1, no refills, start at cycle 0 → byte_ready cycles 1–2; enables 1_2@3, 2_3@4, final@5; done@6; busy 1–5.
- N=4, no refills → pipeline_reg_1_2 cycles 3–6, 2_3 cycles 4–7, final cycles 5–8, exactly 4 final pulses, done@9.
- N=4, refill_req=2 on 2nd retirement, byte_valid=1 → 2 stall cycles with all enables 0 and byte_ready=1, load_window ×2, done@11.
- Last symbol refill_req=1 with byte_valid low 3 cycles → REFILL holds, done only after the byte transfers; start pulses during busy ignored.
- N=0 → DONE next cycle, done pulse, no byte_ready and no enables; refill_req=3 case consumes exactly 2 bytes.
